data_memory: RTL and testbench
==============================

# data_memory

Data-side responder for the single-cycle core's load/store interface: the counterpart of the control unit's `memory_we`, `memory_mask` and `memory_sign_extension` outputs. It is a byte-addressed, little-endian RAM with byte/halfword/word access, load sign/zero extension, a reset-time clear sequencer and sticky misalignment reporting. It sits between the ALU result (address), the register file (store data) and the write-back mux (load data).

## Interface
Parameters:
- `WORDS`, default 256: depth in 32-bit words; must be a power of two ≥ 2.

Ports:
- `clk`  in  1  clock; every state change happens on its rising edge.
- `rst_n`  in  1  reset; synchronous and active-low.
- `addr`  in  32  byte address from the ALU.
- `write_data`  in  32  store data from rs2; byte/half taken from bits [7:0]/[15:0].
- `memory_we`  in  1  store request.
- `memory_re`  in  1  load request; used only for fault detection.
- `memory_mask`  in  memory_mask_t  access width: `MEM_BYTE`, `MEM_HALFWORD`, `MEM_WORD`.
- `memory_sign_extension`  in  1  1 = sign-extend loads, 0 = zero-extend.
- `read_data`  out  32  extended load data.
- `ready`  out  1  clear sequence done; accesses are honoured.
- `misaligned`  out  1  sticky fault flag.
- `fault_addr`  out  32  address of the first misaligned access.

## Operation
- States: `DM_CLEAR` and `DM_READY`.
- Reset: rst_n low at an edge → `DM_CLEAR`, clear index = 0, `ready` = 0, `misaligned` = 0, `fault_addr` = 0. A reset during `DM_CLEAR` restarts the index at 0.
- `DM_CLEAR`: each cycle writes 0 to word[index] and increments the index. When it writes index `WORDS-1`, the next state is `DM_READY`. Stores are ignored, faults are not recorded, and `read_data` = 0.
- Word index: `addr[$clog2(WORDS)+1:2]`. Upper address bits are ignored, so addresses alias modulo `WORDS*4`.
- Byte lane selection, little-endian:
  - byte at `addr[1:0]` = n occupies bits [8n+7:8n];
  - halfword at `addr[1]` = h occupies bits [16h+15:16h];
  - word occupies bits [31:0].
- Load path (combinational):
  - select the lane, then extend from bit 7 or bit 15 if `memory_sign_extension`, otherwise zero-fill;
  - `MEM_WORD` loads ignore `memory_sign_extension`.
- Store path: on the edge, when `memory_we` && `ready` && aligned, only the selected bytes change.
- Misalignment:
  - halfword with `addr[0]` = 1, or word with `addr[1:0]` ≠ 0;
  - a misaligned store writes nothing;
  - a misaligned access drives `read_data` = 0 regardless of `memory_re`.
- Fault capture: on an edge where `ready` && (`memory_we` || `memory_re`) && misaligned:
  - `misaligned` ← 1;
  - `fault_addr` ← `addr`, but only if `misaligned` was 0.
  - Both hold until reset.
- Simultaneous `memory_we` and `memory_re` are legal; it is treated as a store.

## Timing
- The clear sequence takes `WORDS` cycles. `ready` rises on the `WORDS`-th rising edge after the first edge at which rst_n is sampled high.
- Load latency is 0 cycles: `read_data` follows `addr` and `memory_mask` combinationally from memory contents.
- A store takes effect at the edge. In the same cycle `read_data` shows the old data; from the following cycle it shows the new data.
- `misaligned` and `fault_addr` update at the edge after the faulting cycle.
- Reset value of every output: `read_data` = 0 (forced during `DM_CLEAR`), `ready` = 0, `misaligned` = 0, `fault_addr` = 0.

## Structure
- `memory_mask_t` remains in `cpu_types`.
- Add `data_memory_state_t` (`DM_CLEAR`, `DM_READY`) to `cpu_types`.
- One sub-module is natural: `load_extender`, a combinational block taking word, `addr[1:0]`, mask and sign → 32-bit result.
- Storage is a single `logic [31:0]` array with per-byte write enables generated in the top module.

## Test plan
- Reset clear (`WORDS`=16, memory preloaded with garbage via a prior run): release rst_n → `ready` = 0 for 15 edges and 1 after the 16th. All 16 words then read 0. A `memory_we` asserted during clear leaves the memory unchanged.
- Word store then load:
  - sw 0xDEADBEEF @0x8, then lw @0x8 → 0xDEADBEEF;
  - lb @0xB → 0xFFFFFFDE; lbu @0xB → 0x000000DE;
  - lh @0xA → 0xFFFFDEAD; lhu @0x8 → 0x0000BEEF.
- Partial stores:
  - sb 0x7F @0x9 → lw @0x8 = 0xDEAD7FEF;
  - sh 0x1234 @0xA → lw @0x8 = 0x12347FEF;
  - the read during the store cycle returns the old value.
- Misalignment:
  - sw 0xFFFFFFFF @0x6 → word @0x4 unchanged, `misaligned` = 1 and `fault_addr` = 0x6 next cycle;
  - a following lh @0x3 keeps `fault_addr` = 0x6;
  - the misaligned load returns 0.
- Aliasing and mid-clear reset (`WORDS`=16):
  - sw 0xA5A5A5A5 @0x40 → lw @0x0 = 0xA5A5A5A5;
  - asserting rst_n low at clear index 7 → `ready` first rises exactly 16 edges after rst_n is sampled high again, and `misaligned`/`fault_addr` read 0.

Source files
------------

// File: rtl/cpu_types.sv
// Shared core types: load/store access width and data-memory sequencer states,
// plus the lane helpers used by the data-side memory.
package cpu_types;

  typedef enum logic [1:0] {
    MEM_BYTE     = 2'b00,
    MEM_HALFWORD = 2'b01,
    MEM_WORD     = 2'b10
  } memory_mask_t;

  typedef enum logic {
    DM_CLEAR = 1'b0,
    DM_READY = 1'b1
  } data_memory_state_t;

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic access_misaligned(input memory_mask_t mask,
                                             input logic [1:0]   off);
    logic mis;
    mis = 1'b0;
    case (mask)
      MEM_BYTE:     mis = 1'b0;
      MEM_HALFWORD: mis = off[0];
      default:      mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] byte_enables(input memory_mask_t mask,
                                              input logic [1:0]   off);
    logic [3:0] be;
    be = '0;
    case (mask)
      MEM_BYTE:     be = 4'b0001 << off;
      MEM_HALFWORD: be = off[1] ? 4'b1100 : 4'b0011;
      default:      be = '1;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/data_memory_load_extender.sv
// Picks the addressed byte/halfword lane out of a memory word and sign- or
// zero-extends it to 32 bits; word loads pass straight through.
module load_extender
  import cpu_types::*;
(
  input  logic [31:0]  word_i,
  input  logic [1:0]   off_i,
  input  memory_mask_t mask_i,
  input  logic         sign_i,
  output logic [31:0]  result_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = '0;
    case (off_i)
      2'd0:    byte_lane = word_i[7:0];
      2'd1:    byte_lane = word_i[15:8];
      2'd2:    byte_lane = word_i[23:16];
      default: byte_lane = word_i[31:24];
    endcase
    half_lane = off_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    result_o = '0;
    case (mask_i)
      MEM_BYTE:     result_o = {{24{sign_i & byte_lane[7]}}, byte_lane};
      MEM_HALFWORD: result_o = {{16{sign_i & half_lane[15]}}, half_lane};
      default:      result_o = word_i;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// Byte-addressed little-endian data RAM with a power-on clear sequencer and
// sticky capture of the first misaligned access address.
module data_memory
  import cpu_types::*;
#(
  parameter int unsigned WORDS = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  addr,
  input  logic [31:0]  write_data,
  input  logic         memory_we,
  input  logic         memory_re,
  input  memory_mask_t memory_mask,
  input  logic         memory_sign_extension,
  output logic [31:0]  read_data,
  output logic         ready,
  output logic         misaligned,
  output logic [31:0]  fault_addr
);

  localparam int unsigned AW = $clog2(WORDS);
  localparam logic [AW-1:0] LAST_IDX = AW'(WORDS - 1);

  data_memory_state_t state_q, state_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic               mis_q, mis_d;
  logic [31:0]        fault_addr_q, fault_addr_d;

  logic [31:0]        mem_q [WORDS];

  logic [AW-1:0]      word_idx;
  logic [1:0]         byte_off;
  logic               access_mis;
  logic [3:0]         byte_we;
  logic [31:0]        wr_lanes;
  logic               clear_we;
  logic [31:0]        load_word;
  logic [31:0]        load_ext;
  logic               unused_addr;

  // Upper address bits alias the array modulo WORDS*4 bytes.
  assign word_idx    = addr[AW+1:2];
  assign byte_off    = addr[1:0];
  assign unused_addr = ^addr[31:AW+2];

  assign ready      = (state_q == DM_READY);
  assign access_mis = access_misaligned(memory_mask, byte_off);
  assign clear_we   = (state_q == DM_CLEAR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= DM_CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      DM_CLEAR: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = DM_READY;
        end
      end
      default: state_d = DM_READY;
    endcase
  end

  always_comb begin
    byte_we = '0;
    if (ready && memory_we && !access_mis) begin
      byte_we = byte_enables(memory_mask, byte_off);
    end
    // Narrow stores are replicated so every lane sees the right source bits.
    case (memory_mask)
      MEM_BYTE:     wr_lanes = {4{write_data[7:0]}};
      MEM_HALFWORD: wr_lanes = {2{write_data[15:0]}};
      default:      wr_lanes = write_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (clear_we) begin
        mem_q[idx_q] <= '0;
      end else begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (byte_we[b]) begin
            mem_q[word_idx][8*b +: 8] <= wr_lanes[8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    mis_d        = mis_q;
    fault_addr_d = fault_addr_q;
    if (ready && (memory_we || memory_re) && access_mis) begin
      mis_d = 1'b1;
      if (!mis_q) begin
        fault_addr_d = addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mis_q        <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      mis_q        <= mis_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign misaligned = mis_q;
  assign fault_addr = fault_addr_q;

  assign load_word = mem_q[word_idx];

  load_extender u_load_extender (
    .word_i   (load_word),
    .off_i    (byte_off),
    .mask_i   (memory_mask),
    .sign_i   (memory_sign_extension),
    .result_o (load_ext)
  );

  assign read_data = (ready && !access_mis) ? load_ext : '0;

endmodule

// File: tb/tb_data_memory.sv
// Randomized and directed checks of data_memory against a byte-array model.
module tb_data_memory;
  import cpu_types::*;

  localparam int unsigned WORDS = 16;
  localparam int unsigned BYTES = WORDS * 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  addr;
  logic [31:0]  write_data;
  logic         memory_we;
  logic         memory_re;
  memory_mask_t memory_mask;
  logic         memory_sign_extension;
  logic [31:0]  read_data;
  logic         ready;
  logic         misaligned;
  logic [31:0]  fault_addr;

  data_memory #(.WORDS(WORDS)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .addr                  (addr),
    .write_data            (write_data),
    .memory_we             (memory_we),
    .memory_re             (memory_re),
    .memory_mask           (memory_mask),
    .memory_sign_extension (memory_sign_extension),
    .read_data             (read_data),
    .ready                 (ready),
    .misaligned            (misaligned),
    .fault_addr            (fault_addr)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: flat byte array plus cycles-since-reset counter.
  logic [7:0]  mb [BYTES];
  int unsigned m_clr;
  logic        m_mis;
  logic [31:0] m_fa;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic model_mis();
    int unsigned a;
    a = addr % 4;
    if (memory_mask == MEM_HALFWORD) return (a % 2) != 0;
    if (memory_mask == MEM_WORD)     return a != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load();
    int unsigned a;
    logic [31:0] v;
    a = addr % BYTES;
    if (m_clr < WORDS || model_mis()) return 32'd0;
    case (memory_mask)
      MEM_BYTE: begin
        v = 32'(mb[a]);
        if (memory_sign_extension && v >= 128) v = v - 32'd256;
      end
      MEM_HALFWORD: begin
        v = 32'(mb[a]) + 32'(mb[a+1]) * 256;
        if (memory_sign_extension && v >= 32768) v = v - 32'd65536;
      end
      default: v = 32'(mb[a]) + (32'(mb[a+1]) << 8) + (32'(mb[a+2]) << 16) + (32'(mb[a+3]) << 24);
    endcase
    return v;
  endfunction

  // Advance the model by one edge using the currently driven inputs, then clock.
  task automatic tick();
    int unsigned a, n;
    logic [31:0] wd;
    if (!rst_n) begin
      m_clr = 0;
      m_mis = 1'b0;
      m_fa  = '0;
    end else if (m_clr < WORDS) begin
      for (int unsigned k = 0; k < 4; k++) mb[4*m_clr + k] = 8'h00;
      m_clr++;
    end else begin
      if ((memory_we || memory_re) && model_mis()) begin
        if (!m_mis) m_fa = addr;
        m_mis = 1'b1;
      end
      if (memory_we && !model_mis()) begin
        a  = addr % BYTES;
        n  = (memory_mask == MEM_BYTE) ? 1 : (memory_mask == MEM_HALFWORD) ? 2 : 4;
        wd = write_data;
        for (int unsigned k = 0; k < n; k++) begin
          mb[a+k] = wd[7:0];
          wd = wd >> 8;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic re, input memory_mask_t m,
                       input logic sg, input logic [31:0] a, input logic [31:0] wd);
    memory_we             = we;
    memory_re             = re;
    memory_mask           = m;
    memory_sign_extension = sg;
    addr                  = a;
    write_data            = wd;
    #1;
  endtask

  // Full-state comparison against the model, then one edge.
  task automatic access(input string tag, input logic we, input logic re, input memory_mask_t m,
                        input logic sg, input logic [31:0] a, input logic [31:0] wd);
    drive(we, re, m, sg, a, wd);
    check_eq({tag, ".rd"}, read_data, model_load());
    check_eq({tag, ".ready"}, 32'(ready), 32'(m_clr >= WORDS));
    check_eq({tag, ".mis"}, 32'(misaligned), 32'(m_mis));
    check_eq({tag, ".fa"}, fault_addr, m_fa);
    tick();
  endtask

  task automatic load_exp(input string tag, input memory_mask_t m, input logic sg,
                          input logic [31:0] a, input logic [31:0] exp);
    drive(1'b0, 1'b1, m, sg, a, 32'd0);
    check_eq(tag, read_data, exp);
    tick();
  endtask

  task automatic clear_run(input string tag, input bit poke);
    for (int unsigned e = 1; e <= WORDS; e++) begin
      if (poke) drive(1'b1, 1'b1, MEM_WORD, 1'b0, 32'(4 * $urandom_range(0, WORDS-1)), $urandom);
      check_eq({tag, ".rd_clr"}, read_data, 32'd0);
      tick();
      check_eq({tag, ".ready_edge"}, 32'(ready), 32'(e == WORDS));
    end
    drive(1'b0, 1'b0, MEM_WORD, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    for (int unsigned i = 0; i < BYTES; i++) mb[i] = 8'h00;
    m_clr = 0; m_mis = 1'b0; m_fa = '0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, MEM_WORD, 1'b0, 32'd0, 32'd0);
    tick();
    tick();
    check_eq("rst.ready", 32'(ready), 32'd0);
    check_eq("rst.mis", 32'(misaligned), 32'd0);
    check_eq("rst.fa", fault_addr, 32'd0);
    check_eq("rst.rd", read_data, 32'd0);
    rst_n = 1'b1;
    clear_run("clr0", 1'b0);

    // Word store then loads of every width.
    access("sw8", 1'b1, 1'b0, MEM_WORD, 1'b0, 32'h8, 32'hDEADBEEF);
    load_exp("lw8",   MEM_WORD,     1'b0, 32'h8, 32'hDEADBEEF);
    load_exp("lbB",   MEM_BYTE,     1'b1, 32'hB, 32'hFFFFFFDE);
    load_exp("lbuB",  MEM_BYTE,     1'b0, 32'hB, 32'h000000DE);
    load_exp("lhA",   MEM_HALFWORD, 1'b1, 32'hA, 32'hFFFFDEAD);
    load_exp("lhu8",  MEM_HALFWORD, 1'b0, 32'h8, 32'h0000BEEF);

    // Partial stores; read during the store cycle shows the old lane.
    drive(1'b1, 1'b0, MEM_BYTE, 1'b0, 32'h9, 32'h0000007F);
    check_eq("sb9.old", read_data, 32'h000000BE);
    tick();
    load_exp("sb9.lw", MEM_WORD, 1'b0, 32'h8, 32'hDEAD7FEF);
    drive(1'b1, 1'b0, MEM_HALFWORD, 1'b0, 32'hA, 32'h00001234);
    check_eq("shA.old", read_data, 32'h0000DEAD);
    tick();
    load_exp("shA.lw", MEM_WORD, 1'b0, 32'h8, 32'h12347FEF);

    // Misaligned store, then a second misaligned load keeps the first address.
    drive(1'b1, 1'b0, MEM_WORD, 1'b0, 32'h6, 32'hFFFFFFFF);
    check_eq("sw6.rd", read_data, 32'd0);
    check_eq("sw6.mis_pre", 32'(misaligned), 32'd0);
    tick();
    check_eq("sw6.mis", 32'(misaligned), 32'd1);
    check_eq("sw6.fa", fault_addr, 32'h6);
    load_exp("sw6.lw4", MEM_WORD, 1'b0, 32'h4, 32'h00000000);
    load_exp("lh3.rd", MEM_HALFWORD, 1'b1, 32'h3, 32'h00000000);
    check_eq("lh3.fa", fault_addr, 32'h6);
    check_eq("lh3.mis", 32'(misaligned), 32'd1);
    m_mis = 1'b1; m_fa = 32'h6;

    // Aliasing modulo WORDS*4.
    access("sw40", 1'b1, 1'b0, MEM_WORD, 1'b0, 32'h40, 32'hA5A5A5A5);
    load_exp("alias.lw0", MEM_WORD, 1'b0, 32'h0, 32'hA5A5A5A5);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      access("rnd", 1'($urandom), 1'($urandom), memory_mask_t'($urandom_range(0, 2)),
             1'($urandom), 32'($urandom_range(0, 4*BYTES - 1)), $urandom);
    end

    // Fill with garbage so the clear is observable.
    for (int unsigned w = 0; w < WORDS; w++) access("fill", 1'b1, 1'b0, MEM_WORD, 1'b0, 32'(4*w), $urandom | 32'h1);

    // Reset, stop mid-clear at index 7, reset again; stores during clear are ignored.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 7; k++) tick();
    check_eq("mid.ready", 32'(ready), 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    clear_run("clr1", 1'b1);
    check_eq("clr1.mis", 32'(misaligned), 32'd0);
    check_eq("clr1.fa", fault_addr, 32'd0);
    for (int unsigned w = 0; w < WORDS; w++) load_exp("clr1.zero", MEM_WORD, 1'b0, 32'(4*w), 32'd0);

    for (int i = 0; i < 100; i++) begin
      access("rnd2", 1'($urandom), 1'($urandom), memory_mask_t'($urandom_range(0, 2)),
             1'($urandom), 32'($urandom_range(0, 4*BYTES - 1)), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
